demux_stream: RTL and testbench

- 1-to-4 registered demultiplexer: the distributing counterpart to the team's 4:1 selector mux.
- Takes one input word stream and steers each accepted word to one of four output channels.
- Channel is chosen either by an external select or by an internal round-robin pointer.
- Each output channel has a one-entry holding register with a valid/ready handshake, so downstream consumers can stall independently.

---
 rtl/demux_stream_pkg.sv | 12 +
 rtl/demux_chan_reg.sv | 34 +++
 rtl/demux_stream.sv | 83 ++++++++
 tb/tb_demux_stream.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// Shared constants and the round-robin pointer helper for the 1-to-4 stream demultiplexer.
package demux_stream_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Advance the channel pointer, wrapping from the last channel back to 0.
    function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] p);
        return (p == SEL_W'(NUM_CH - 1)) ? '0 : p + SEL_W'(1);
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output holding register with a valid/ready handshake.
module demux_chan_reg #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // NOTE: state is updated with <= only, so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            // A load wins over a same-cycle drain: the slot refills.
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/demux_stream.sv
// 1-to-4 registered demultiplexer: steers each accepted word to a channel chosen
// by Sel or by an internal round-robin pointer, with per-channel backpressure.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] In,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       Sel,
    input  logic             AutoMode,
    output logic [WIDTH-1:0] Out0,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic [WIDTH-1:0] Out3,
    output logic             Valid0,
    output logic             Valid1,
    output logic             Valid2,
    output logic             Valid3,
    input  logic             Ready0,
    input  logic             Ready1,
    input  logic             Ready2,
    input  logic             Ready3,
    output logic [1:0]       CurSel,
    output logic [CNT_W-1:0] AcceptCount
);

    logic [SEL_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [SEL_W-1:0]  w_sel;
    logic              w_accept;
    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_ready;
    logic [NUM_CH-1:0] w_load;
    logic [WIDTH-1:0]  w_out [NUM_CH];

    assign w_ready = {Ready3, Ready2, Ready1, Ready0};
    assign w_sel   = AutoMode ? r_ptr : Sel;
    // Only the selected channel gates the input: a stalled target blocks the stream.
    assign InReady  = !Rst && (!w_valid[w_sel] || w_ready[w_sel]);
    assign w_accept = InValid && InReady;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_load[k] = w_accept && (w_sel == SEL_W'(k));

        demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
            .Clk     (Clk),
            .Rst     (Rst),
            .i_load  (w_load[k]),
            .i_data  (In),
            .i_ready (w_ready[k]),
            .o_data  (w_out[k]),
            .o_valid (w_valid[k])
        );
    end

    // Pointer is frozen in manual mode so auto mode resumes where it left off.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (AutoMode) r_ptr <= ptr_next(r_ptr);
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign CurSel      = w_sel;
    assign AcceptCount = r_cnt;
    assign Out0   = w_out[0];
    assign Out1   = w_out[1];
    assign Out2   = w_out[2];
    assign Out3   = w_out[3];
    assign Valid0 = w_valid[0];
    assign Valid1 = w_valid[1];
    assign Valid2 = w_valid[2];
    assign Valid3 = w_valid[3];

endmodule

// File: tb/tb_demux_stream.sv
// Randomized bench for demux_stream against a per-channel slot model; a second
// instance with a 4-bit counter exercises saturation on the same stimulus.
module tb_demux_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       in_valid;
    logic [1:0] sel;
    logic       auto_mode;
    logic [3:0] ready;

    logic        in_ready, in_ready_s;
    logic [1:0]  cur_sel, cur_sel_s;
    logic [7:0]  out   [4];
    logic [7:0]  out_s [4];
    logic [3:0]  valid, valid_s;
    logic [15:0] acc_cnt;
    logic [3:0]  acc_cnt_s;

    int errors = 0;
    int checks = 0;

    // Reference model: one slot per channel, a round-robin index and a plain integer count.
    logic [7:0] m_data  [4];
    bit         m_valid [4];
    int         m_ptr;
    int         m_cnt;

    always #5 clk = ~clk;

    demux_stream dut (
        .Clk(clk), .Rst(rst), .In(din), .InValid(in_valid), .InReady(in_ready),
        .Sel(sel), .AutoMode(auto_mode),
        .Out0(out[0]), .Out1(out[1]), .Out2(out[2]), .Out3(out[3]),
        .Valid0(valid[0]), .Valid1(valid[1]), .Valid2(valid[2]), .Valid3(valid[3]),
        .Ready0(ready[0]), .Ready1(ready[1]), .Ready2(ready[2]), .Ready3(ready[3]),
        .CurSel(cur_sel), .AcceptCount(acc_cnt)
    );

    demux_stream #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .Clk(clk), .Rst(rst), .In(din), .InValid(in_valid), .InReady(in_ready_s),
        .Sel(sel), .AutoMode(auto_mode),
        .Out0(out_s[0]), .Out1(out_s[1]), .Out2(out_s[2]), .Out3(out_s[3]),
        .Valid0(valid_s[0]), .Valid1(valid_s[1]), .Valid2(valid_s[2]), .Valid3(valid_s[3]),
        .Ready0(ready[0]), .Ready1(ready[1]), .Ready2(ready[2]), .Ready3(ready[3]),
        .CurSel(cur_sel_s), .AcceptCount(acc_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check combinational outputs,
    // step the model at the rising edge, then check registered state.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                         input logic [1:0] s_in, input logic a, input logic [3:0] rd);
        int  s;
        bit  exp_ready;
        bit  acc;
        rst = r; in_valid = v; din = d; sel = s_in; auto_mode = a; ready = rd;
        #1;
        s = a ? m_ptr : int'(s_in);
        exp_ready = !r && (!m_valid[s] || rd[s]);
        check("cur_sel", 32'(cur_sel), 32'(s));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 4; k++) begin m_valid[k] = 0; m_data[k] = '0; end
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            for (int k = 0; k < 4; k++) if (m_valid[k] && rd[k]) m_valid[k] = 0;
            if (acc) begin
                m_data[s]  = d;
                m_valid[s] = 1;
                if (a) m_ptr = (m_ptr + 1) % 4;
                m_cnt++;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out%0d", k), 32'(out[k]), 32'(m_data[k]));
            check($sformatf("valid%0d", k), 32'(valid[k]), 32'(m_valid[k]));
        end
        check("accept_count", 32'(acc_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
        check("accept_count_sat", 32'(acc_cnt_s), 32'((m_cnt > 15) ? 15 : m_cnt));
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin m_valid[k] = 0; m_data[k] = '0; end
        m_ptr = 0;
        m_cnt = 0;
        @(negedge clk);

        // Reset then idle
        cycle(1, 0, 8'h00, 2'd0, 0, 4'h0);
        cycle(1, 0, 8'h00, 2'd0, 0, 4'h0);
        cycle(0, 0, 8'h00, 2'd0, 0, 4'h0);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Manual steer to channel 2
        cycle(0, 1, 8'hA5, 2'd2, 0, 4'h0);
        check("steer_out2", 32'(out[2]), 32'hA5);
        check("steer_valids", 32'(valid), 32'b0100);
        check("steer_count", 32'(acc_cnt), 32'd1);

        // Stall on channel 1, then pass-through when Ready1 rises
        cycle(0, 1, 8'h11, 2'd1, 0, 4'h0);
        cycle(0, 1, 8'h22, 2'd1, 0, 4'h0);
        check("stall_out1", 32'(out[1]), 32'h11);
        cycle(0, 1, 8'h22, 2'd1, 0, 4'b0010);
        check("pass_out1", 32'(out[1]), 32'h22);
        check("pass_valid1", 32'(valid[1]), 32'd1);

        // Round-robin stream of five words after a clean reset
        cycle(1, 0, 8'h00, 2'd0, 0, 4'h0);
        for (int i = 1; i <= 5; i++) cycle(0, 1, 8'(i), 2'd3, 1, 4'hF);
        check("rr_out0", 32'(out[0]), 32'h05);
        check("rr_out3", 32'(out[3]), 32'h04);
        check("rr_count", 32'(acc_cnt), 32'd5);
        cycle(0, 0, 8'h00, 2'd0, 1, 4'hF);
        check("rr_ptr", 32'(cur_sel), 32'd1);

        // Mode switch: pointer frozen in manual mode
        cycle(1, 0, 8'h00, 2'd0, 0, 4'h0);
        cycle(0, 1, 8'h31, 2'd0, 1, 4'hF);
        cycle(0, 1, 8'h32, 2'd0, 1, 4'hF);
        cycle(0, 1, 8'h33, 2'd3, 0, 4'hF);
        check("manual_out3", 32'(out[3]), 32'h33);
        cycle(0, 1, 8'h34, 2'd0, 1, 4'hF);
        check("resume_out2", 32'(out[2]), 32'h34);

        // Reset mid-operation with channels 0 and 3 holding data
        cycle(0, 1, 8'h40, 2'd0, 0, 4'h0);
        cycle(0, 1, 8'h43, 2'd3, 0, 4'h0);
        cycle(1, 0, 8'h00, 2'd0, 0, 4'h0);
        check("midrst_valids", 32'(valid), 32'd0);
        check("midrst_count", 32'(acc_cnt), 32'd0);
        cycle(0, 0, 8'h00, 2'd0, 1, 4'h0);
        check("midrst_ptr", 32'(cur_sel), 32'd0);

        // Saturation of the 4-bit counter instance
        for (int i = 0; i < 20; i++) cycle(0, 1, 8'(i), 2'(i), 0, 4'hF);
        check("sat_count", 32'(acc_cnt_s), 32'd15);
        check("wide_count", 32'(acc_cnt), 32'd20);

        // Randomized traffic
        begin
            logic a_rand;
            a_rand = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(7) == 0) a_rand = ~a_rand;
                cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0), 8'($urandom),
                      2'($urandom), a_rand, 4'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
